alarm_timer: RTL and testbench
==============================

# alarm_timer

Countdown timekeeper for the alarm clock: holds an mm:ss value set by the user, counts it down once per second, and raises an alarm on reaching 00:00. It sits directly upstream of the VGA character renderer and drives its `minutes_tens`, `minutes_ones`, `seconds_tens` and `seconds_ones` digit inputs. Button inputs come from the debounce stage as single-cycle pulses.

## Interface

Parameters:
- `CLK_FREQ`, default 100_000_000: clk cycles per second tick. Must be ≥ 2.
- `ALARM_SECS`, default 10: number of seconds `alarm` stays high without user action.

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `btn_start`  in  1  pulse; start/pause toggle, alarm acknowledge.
- `btn_clear`  in  1  pulse; abort to IDLE and set time to 00:00.
- `btn_set_min`  in  1  pulse; increment minutes (IDLE only).
- `btn_set_sec`  in  1  pulse; increment seconds (IDLE only).
- `minutes_tens`  out  3  BCD 0..5, registered.
- `minutes_ones`  out  4  BCD 0..9, registered.
- `seconds_tens`  out  3  BCD 0..5, registered.
- `seconds_ones`  out  4  BCD 0..9, registered.
- `running`  out  1  high in RUN.
- `alarm`  out  1  high in ALARM.

## Operation

- State machine states are IDLE, RUN, PAUSE and ALARM. Reset puts it in IDLE.
- Reset values:
  - All four digit outputs are 0.
  - `running` = 0 and `alarm` = 0.
  - The prescaler is 0.
  - The alarm-second counter is 0.
- Input priority within one cycle: `btn_clear` > `btn_start` > set buttons. `btn_set_min` and `btn_set_sec` in the same cycle both apply.
- IDLE:
  - `btn_set_min` advances minutes 00→01→…→59→00.
  - `btn_set_sec` advances seconds the same way. There is no carry into minutes.
  - `btn_start` with time ≠ 00:00 goes to RUN and clears the prescaler. With time = 00:00 it is ignored.
  - `btn_clear` sets the time to 00:00 and stays in IDLE.
- RUN:
  - The prescaler counts 0..CLK_FREQ-1. The tick is the cycle in which it equals CLK_FREQ-1, and the prescaler then wraps to 0.
  - On each tick the time decrements by one second:
    - ones 0 borrows from tens, giving x9;
    - seconds 00 borrows from minutes, giving 59.
  - The tick that takes 00:01 to 00:00 also transitions to ALARM.
  - `btn_start` goes to PAUSE, holding both the time and the prescaler value.
  - `btn_clear` goes to IDLE with time 00:00.
  - Set buttons are ignored.
- PAUSE:
  - `btn_start` returns to RUN, resuming from the held prescaler value.
  - `btn_clear` goes to IDLE with time 00:00.
  - Set buttons are ignored.
- ALARM:
  - Time stays at 00:00 and `alarm` = 1.
  - The prescaler keeps running. Each tick increments the alarm-second counter.
  - After ALARM_SECS ticks the block goes to IDLE and the counter clears.
  - `btn_start` or `btn_clear` goes to IDLE immediately and the counter clears.
- A tick and `btn_start` in the same RUN cycle: the pause takes effect and the tick is dropped; the time does not decrement.
- A tick and `btn_clear` in the same cycle: the clear wins.
- Minutes never exceed 59. Every arithmetic step operates per BCD digit with explicit borrow or carry; there is no binary-to-BCD conversion.

## Timing

- All outputs are registered.
- A button pulse in cycle N is reflected on the outputs and state in cycle N+1.
- First decrement after a start in cycle N: the digits change in cycle N+CLK_FREQ+1, because the prescaler counts 0..CLK_FREQ-1 and the registered update adds one cycle.
- `alarm` rises in the same cycle the digits show 00:00 after the final decrement.
- `alarm` falls one cycle after the ALARM_SECS-th alarm tick, or one cycle after an acknowledge pulse.
- A reset asserted in any state (mid-count, mid-alarm) returns every output to its reset value on the next edge. No partial state survives.

## Structure

- Shared header `alarm_defs.vh` holds:
  - the state encodings `ST_IDLE`, `ST_RUN`, `ST_PAUSE`, `ST_ALARM`;
  - digit limits `TENS_MAX = 5` and `ONES_MAX = 9`.
- One sub-module, `bcd60_counter`, instantiated twice (minutes and seconds). It is a two-digit 00..59 counter with:
  - inputs `inc`, `dec`, `clr`;
  - output `borrow`, asserted when `dec` is applied at 00.
- The top level contains only the FSM, the prescaler, the alarm-second counter, and the borrow chaining (seconds borrow → minutes dec).

## Test plan

Run all scenarios with CLK_FREQ=4 and ALARM_SECS=3.

- Reset during RUN at 01:23 → next cycle: all digits 0, `running`=0, `alarm`=0, state IDLE.
- In IDLE, 61 `btn_set_sec` pulses → display 00:01. 60 `btn_set_min` pulses → 00:01 unchanged.
- Set 01:00, start in cycle N → cycle N+5 shows 00:59 and `running`=1. `running` stays 1 through the decrements to 00:00. Next change is 00:58 four cycles later.
- Set 00:02 and start → after 2 ticks: 00:00 with `alarm`=1 in the same cycle. `alarm` is held for 3 ticks (12 cycles), then drops to IDLE.
- Start at 00:05, pause after 1 tick, wait 20 cycles → display stays 00:04. Resume → 00:03 appears after the remaining prescaler count.
- During ALARM, `btn_start` → `alarm`=0 next cycle, state IDLE.
- In RUN, `btn_clear` and `btn_start` in the same cycle → IDLE at 00:00, `running`=0.

Source files
------------

// File: rtl/alarm_timer_pkg.sv
// Shared definitions for the alarm timer: FSM encodings, BCD digit limits and
// the two-digit 00..59 value type used for both minutes and seconds.
package alarm_timer_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_ALARM = 2'd3;

    localparam logic [2:0] TENS_MAX = 3'd5;
    localparam logic [3:0] ONES_MAX = 4'd9;

    typedef struct packed {
        logic [2:0] tens;
        logic [3:0] ones;
    } bcd60_t;

    function automatic logic bcd60_is(input bcd60_t v, input logic [3:0] ones);
        return (v.tens == 3'd0) && (v.ones == ones);
    endfunction

endpackage

// File: rtl/alarm_timer_bcd60_counter.sv
// Two-digit BCD counter wrapping 00..59 in both directions; borrow flags a
// decrement applied at 00 so the next field up can be decremented too.
module bcd60_counter
    import alarm_timer_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   inc,
    input  logic   dec,
    input  logic   clr,
    output bcd60_t value,
    output logic   borrow
);

    assign borrow = dec && !clr && bcd60_is(value, 4'd0);

    // Clear wins over decrement, decrement wins over increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (dec) begin
            if (value.ones == 4'd0) begin
                value.ones <= ONES_MAX;
                value.tens <= (value.tens == 3'd0) ? TENS_MAX : value.tens - 3'd1;
            end else begin
                value.ones <= value.ones - 4'd1;
            end
        end else if (inc) begin
            if (value.ones == ONES_MAX) begin
                value.ones <= 4'd0;
                value.tens <= (value.tens == TENS_MAX) ? 3'd0 : value.tens + 3'd1;
            end else begin
                value.ones <= value.ones + 4'd1;
            end
        end
    end

endmodule

// File: rtl/alarm_timer.sv
// Countdown mm:ss timer with start/pause, clear, IDLE-only time setting and a
// timed alarm that ends on its own or on acknowledge.
module alarm_timer
    import alarm_timer_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int ALARM_SECS = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start,
    input  logic       btn_clear,
    input  logic       btn_set_min,
    input  logic       btn_set_sec,
    output logic [2:0] minutes_tens,
    output logic [3:0] minutes_ones,
    output logic [2:0] seconds_tens,
    output logic [3:0] seconds_ones,
    output logic       running,
    output logic       alarm
);

    localparam int PRE_W  = (CLK_FREQ > 2) ? $clog2(CLK_FREQ) : 1;
    localparam int ACNT_W = (ALARM_SECS > 1) ? $clog2(ALARM_SECS) : 1;
    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(CLK_FREQ - 1);
    localparam logic [PRE_W-1:0]  PRE_ONE   = PRE_W'(1);
    localparam logic [ACNT_W-1:0] ACNT_LAST = ACNT_W'(ALARM_SECS - 1);
    localparam logic [ACNT_W-1:0] ACNT_ONE  = ACNT_W'(1);

    logic [1:0]        state, state_next;
    logic [PRE_W-1:0]  prescaler, prescaler_next;
    logic [ACNT_W-1:0] alarm_cnt, alarm_cnt_next;

    bcd60_t minutes, seconds;
    logic   tick, time_zero, time_one;
    logic   set_ok, sec_inc, min_inc, sec_dec, sec_borrow, min_borrow;

    assign tick      = (prescaler == PRE_LAST);
    assign time_zero = bcd60_is(minutes, 4'd0) && bcd60_is(seconds, 4'd0);
    assign time_one  = bcd60_is(minutes, 4'd0) && bcd60_is(seconds, 4'd1);

    // Set buttons only act in IDLE and lose to start/clear in the same cycle.
    assign set_ok  = (state == ST_IDLE) && !btn_clear && !btn_start;
    assign sec_inc = set_ok && btn_set_sec;
    assign min_inc = set_ok && btn_set_min;
    assign sec_dec = (state == ST_RUN) && tick && !btn_clear && !btn_start;

    bcd60_counter u_seconds (
        .clk    (clk),
        .rst    (rst),
        .inc    (sec_inc),
        .dec    (sec_dec),
        .clr    (btn_clear),
        .value  (seconds),
        .borrow (sec_borrow)
    );

    bcd60_counter u_minutes (
        .clk    (clk),
        .rst    (rst),
        .inc    (min_inc),
        .dec    (sec_borrow),
        .clr    (btn_clear),
        .value  (minutes),
        .borrow (min_borrow)
    );

    always_comb begin
        state_next     = state;
        prescaler_next = prescaler;
        alarm_cnt_next = alarm_cnt;
        case (state)
            ST_IDLE: begin
                prescaler_next = '0;
                alarm_cnt_next = '0;
                if (!btn_clear && btn_start && !time_zero) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (btn_clear) begin
                    state_next     = ST_IDLE;
                    prescaler_next = '0;
                end else if (btn_start) begin
                    state_next = ST_PAUSE;
                end else begin
                    prescaler_next = tick ? '0 : prescaler + PRE_ONE;
                    // A minutes underflow would mean 00:00 was passed; treat it as expiry too.
                    if (tick && (time_one || min_borrow)) begin
                        state_next = ST_ALARM;
                    end
                end
            end
            ST_PAUSE: begin
                if (btn_clear) begin
                    state_next     = ST_IDLE;
                    prescaler_next = '0;
                end else if (btn_start) begin
                    state_next = ST_RUN;
                end
            end
            ST_ALARM: begin
                if (btn_clear || btn_start) begin
                    state_next     = ST_IDLE;
                    prescaler_next = '0;
                    alarm_cnt_next = '0;
                end else begin
                    prescaler_next = tick ? '0 : prescaler + PRE_ONE;
                    if (tick) begin
                        if (alarm_cnt == ACNT_LAST) begin
                            state_next     = ST_IDLE;
                            prescaler_next = '0;
                            alarm_cnt_next = '0;
                        end else begin
                            alarm_cnt_next = alarm_cnt + ACNT_ONE;
                        end
                    end
                end
            end
            default: begin
                state_next     = ST_IDLE;
                prescaler_next = '0;
                alarm_cnt_next = '0;
            end
        endcase
    end

    // Status flags are registered from the next state so they line up with the digits.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            prescaler <= '0;
            alarm_cnt <= '0;
            running   <= 1'b0;
            alarm     <= 1'b0;
        end else begin
            state     <= state_next;
            prescaler <= prescaler_next;
            alarm_cnt <= alarm_cnt_next;
            running   <= (state_next == ST_RUN);
            alarm     <= (state_next == ST_ALARM);
        end
    end

    assign minutes_tens = minutes.tens;
    assign minutes_ones = minutes.ones;
    assign seconds_tens = seconds.tens;
    assign seconds_ones = seconds.ones;

endmodule

// File: tb/tb_alarm_timer.sv
// Self-checking bench for alarm_timer: directed table, hand-written corner
// sequences, then randomized buttons against a seconds-based reference model.
module tb_alarm_timer;

    localparam int CF = 4;
    localparam int AS = 3;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_ALARM = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_start = 1'b0;
    logic       btn_clear = 1'b0;
    logic       btn_set_min = 1'b0;
    logic       btn_set_sec = 1'b0;
    logic [2:0] minutes_tens, seconds_tens;
    logic [3:0] minutes_ones, seconds_ones;
    logic       running, alarm;

    int checks = 0;
    int fails  = 0;

    int m_state = M_IDLE;
    int m_min = 0, m_sec = 0, m_pre = 0, m_acnt = 0;

    typedef struct {
        logic  r, st, cl, sm, ss;
        int    em, es;
        logic  er, ea;
        string name;
    } vec_t;

    always #5 clk = ~clk;

    alarm_timer #(.CLK_FREQ(CF), .ALARM_SECS(AS)) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_start    (btn_start),
        .btn_clear    (btn_clear),
        .btn_set_min  (btn_set_min),
        .btn_set_sec  (btn_set_sec),
        .minutes_tens (minutes_tens),
        .minutes_ones (minutes_ones),
        .seconds_tens (seconds_tens),
        .seconds_ones (seconds_ones),
        .running      (running),
        .alarm        (alarm)
    );

    // Reference model: time kept as whole seconds, one call per clock edge.
    task automatic model_step(input logic r, st, cl, sm, ss);
        int total;
        bit tk;
        if (r) begin
            m_state = M_IDLE; m_min = 0; m_sec = 0; m_pre = 0; m_acnt = 0;
        end else begin
            case (m_state)
                M_IDLE: begin
                    if (cl) begin
                        m_min = 0; m_sec = 0;
                    end else if (st) begin
                        if (m_min * 60 + m_sec != 0) begin
                            m_state = M_RUN; m_pre = 0;
                        end
                    end else begin
                        if (sm) m_min = (m_min + 1) % 60;
                        if (ss) m_sec = (m_sec + 1) % 60;
                    end
                end
                M_RUN: begin
                    if (cl) begin
                        m_state = M_IDLE; m_min = 0; m_sec = 0;
                    end else if (st) begin
                        m_state = M_PAUSE;
                    end else begin
                        tk = (m_pre == CF - 1);
                        m_pre = (m_pre + 1) % CF;
                        if (tk) begin
                            total = m_min * 60 + m_sec - 1;
                            m_min = total / 60;
                            m_sec = total % 60;
                            if (total == 0) begin
                                m_state = M_ALARM; m_acnt = 0;
                            end
                        end
                    end
                end
                M_PAUSE: begin
                    if (cl) begin
                        m_state = M_IDLE; m_min = 0; m_sec = 0;
                    end else if (st) begin
                        m_state = M_RUN;
                    end
                end
                default: begin
                    if (cl || st) begin
                        m_state = M_IDLE; m_acnt = 0;
                    end else begin
                        tk = (m_pre == CF - 1);
                        m_pre = (m_pre + 1) % CF;
                        if (tk) begin
                            m_acnt++;
                            if (m_acnt == AS) begin
                                m_state = M_IDLE; m_acnt = 0;
                            end
                        end
                    end
                end
            endcase
        end
    endtask

    task automatic applyStimulus(input logic r, st, cl, sm, ss);
        rst = r; btn_start = st; btn_clear = cl; btn_set_min = sm; btn_set_sec = ss;
        @(posedge clk);
        #1;
        model_step(r, st, cl, sm, ss);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0);
    endtask

    task automatic checkOutput(input string name, input int em, es, input logic er, ea);
        logic [15:0] got, exp;
        got = {minutes_tens, minutes_ones, seconds_tens, seconds_ones, running, alarm};
        exp = {3'(em / 10), 4'(em % 10), 3'(es / 10), 4'(es % 10), er, ea};
        checks++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d%0d:%0d%0d running=%0b alarm=%0b, expected %02d:%02d running=%0b alarm=%0b",
                     name, minutes_tens, minutes_ones, seconds_tens, seconds_ones, running, alarm,
                     em, es, er, ea);
        end
    endtask

    vec_t vecs[$];

    initial begin
        // Directed table: one clock per entry, expected outputs after that edge.
        vecs.push_back('{1, 0, 0, 0, 0,  0,  0, 0, 0, "reset"});
        vecs.push_back('{0, 0, 0, 0, 1,  0,  1, 0, 0, "set_sec"});
        vecs.push_back('{0, 0, 0, 1, 1,  1,  2, 0, 0, "set_both"});
        vecs.push_back('{0, 1, 0, 1, 0,  1,  2, 1, 0, "start_beats_set"});
        vecs.push_back('{0, 0, 0, 0, 0,  1,  2, 1, 0, "run_pre1"});
        vecs.push_back('{0, 0, 0, 0, 0,  1,  2, 1, 0, "run_pre2"});
        vecs.push_back('{0, 0, 0, 0, 0,  1,  2, 1, 0, "run_pre3"});
        vecs.push_back('{0, 0, 0, 0, 0,  1,  1, 1, 0, "first_tick"});
        vecs.push_back('{0, 1, 0, 0, 0,  1,  1, 0, 0, "pause"});
        vecs.push_back('{0, 0, 0, 1, 1,  1,  1, 0, 0, "set_ignored_pause"});
        vecs.push_back('{0, 1, 0, 0, 0,  1,  1, 1, 0, "resume"});
        vecs.push_back('{0, 0, 0, 1, 0,  1,  1, 1, 0, "set_ignored_run"});
        vecs.push_back('{0, 0, 0, 0, 0,  1,  1, 1, 0, "resume_pre2"});
        vecs.push_back('{0, 0, 0, 0, 0,  1,  1, 1, 0, "resume_pre3"});
        vecs.push_back('{0, 0, 0, 0, 0,  1,  0, 1, 0, "tick_borrow_ones"});
        vecs.push_back('{0, 0, 0, 0, 0,  1,  0, 1, 0, "pre1_at_0100"});
        vecs.push_back('{0, 0, 0, 0, 0,  1,  0, 1, 0, "pre2_at_0100"});
        vecs.push_back('{0, 0, 0, 0, 0,  1,  0, 1, 0, "pre3_at_0100"});
        vecs.push_back('{0, 0, 0, 0, 0,  0, 59, 1, 0, "borrow_minutes"});
        vecs.push_back('{0, 1, 1, 0, 0,  0,  0, 0, 0, "clear_beats_start"});
        vecs.push_back('{0, 1, 0, 0, 0,  0,  0, 0, 0, "start_at_zero"});
        vecs.push_back('{0, 0, 0, 0, 1,  0,  1, 0, 0, "idle_after_clear"});
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].r, vecs[i].st, vecs[i].cl, vecs[i].sm, vecs[i].ss);
            checkOutput(vecs[i].name, vecs[i].em, vecs[i].es, vecs[i].er, vecs[i].ea);
        end

        // Seconds and minutes each wrap at 60 with no carry between them.
        applyStimulus(1, 0, 0, 0, 0);
        for (int i = 0; i < 61; i++) applyStimulus(0, 0, 0, 0, 1);
        checkOutput("sec_wrap_61", 0, 1, 0, 0);
        for (int i = 0; i < 60; i++) applyStimulus(0, 0, 0, 1, 0);
        checkOutput("min_wrap_60", 0, 1, 0, 0);

        // Reset mid-count at 01:23.
        applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 1, 0);
        for (int i = 0; i < 23; i++) applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 1, 0, 0, 0);
        idleCycles(2);
        checkOutput("running_0123", 1, 23, 1, 0);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("reset_in_run", 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("idle_after_reset", 0, 1, 0, 0);

        // 00:02 -> alarm in the same cycle as 00:00, held for AS ticks.
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 1, 0, 0, 0);
        idleCycles(3);
        checkOutput("before_tick_0002", 0, 2, 1, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("tick_to_0001", 0, 1, 1, 0);
        idleCycles(4);
        checkOutput("alarm_rise", 0, 0, 0, 1);
        idleCycles(11);
        checkOutput("alarm_held", 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("alarm_timeout", 0, 0, 0, 0);

        // Acknowledge during alarm.
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 1, 0, 0, 0);
        idleCycles(4);
        checkOutput("alarm_again", 0, 0, 0, 1);
        idleCycles(2);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("alarm_ack", 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("idle_after_ack", 0, 1, 0, 0);

        // Pause keeps the partial prescaler count.
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 1, 0, 0, 0);
        idleCycles(4);
        checkOutput("tick_0004", 0, 4, 1, 0);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        idleCycles(20);
        checkOutput("paused_hold", 0, 4, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        idleCycles(2);
        checkOutput("resume_partial", 0, 4, 1, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("resume_tick", 0, 3, 1, 0);

        // Randomized buttons against the model, alternating busy and quiet phases.
        applyStimulus(1, 0, 0, 0, 0);
        for (int blk = 0; blk < 20; blk++) begin
            bit quiet;
            quiet = blk[0];
            for (int i = 0; i < 200; i++) begin
                logic r, st, cl, sm, ss;
                r  = ($urandom_range(0, 399) == 0);
                cl = ($urandom_range(0, 79) == 0);
                st = quiet ? ($urandom_range(0, 59) == 0) : ($urandom_range(0, 7) == 0);
                sm = quiet ? 1'b0 : ($urandom_range(0, 5) == 0);
                ss = quiet ? 1'b0 : ($urandom_range(0, 2) == 0);
                applyStimulus(r, st, cl, sm, ss);
                checkOutput("random", m_min, m_sec, m_state == M_RUN, m_state == M_ALARM);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
